tone_envelope_pwm: RTL and testbench
====================================

TONE_ENVELOPE_PWM -- requirements
Module: tone_envelope_pwm

Interface
REQ-001 Parameter PRESCALE, default 25000: clk cycles per envelope tick (1 ms at 25 MHz); legal range >= 2.
REQ-002 Parameter ATTACK_STEP, default 8: level increment per tick in ATTACK; legal range 1-255.
REQ-003 Parameter DECAY_STEP, default 2: level decrement per tick in DECAY; legal range 1-255.
REQ-004 Parameter SUSTAIN_LEVEL, default 160: DECAY floor and SUSTAIN hold level; legal range 0-255.
REQ-005 Parameter RELEASE_STEP, default 4: level decrement per tick in RELEASE; legal range 1-255.
REQ-006 Parameter IDLE_TIMEOUT, default 500: ticks spent in IDLE before the amplifier is shut down; legal range >= 1.
REQ-007 Clocking SHALL be: one clock; reset is asynchronous and active-low.
REQ-008 clk  input  1  system clock; all logic rises on posedge clk.
REQ-009 resetn  input  1  asynchronous active-low reset.
REQ-010 tone_in  input  1  square-wave tone from the upstream note generator, clk-synchronous.
REQ-011 note_on  input  1  level, high while a non-rest note is playing, clk-synchronous.
REQ-012 note_change  input  1  one-cycle pulse when the upstream note value changes.
REQ-013 pwm_out  output  1  registered PWM speaker drive.
REQ-014 shutdown  output  1  amplifier enable: 1 = amplifier on, 0 = off.
REQ-015 gain  output  1  amplifier gain select, constant 0.
REQ-016 env_level  output  8  current envelope level, registered.
REQ-017 env_state  output  3  FSM state: IDLE=0, ATTACK=1, DECAY=2, SUSTAIN=3, RELEASE=4.

Function
REQ-018 The prescaler SHALL count 0..PRESCALE-1 free-running from reset, asserting tick for one cycle when the count equals PRESCALE-1.
REQ-019 The block SHALL register note_on and detect rise (note_on=1, prev=0) and fall (note_on=0, prev=1) each cycle.
REQ-020 From IDLE, a rise SHALL move to ATTACK on the next edge, with level unchanged.
REQ-021 In ATTACK, on tick: level = min(level+ATTACK_STEP, 255), computed 9-bit and saturated; on reaching 255 -> DECAY.
REQ-022 In DECAY, on tick: level = max(level-DECAY_STEP, SUSTAIN_LEVEL), no underflow; on reaching SUSTAIN_LEVEL -> SUSTAIN.
REQ-023 If level <= SUSTAIN_LEVEL on entry to DECAY, the next tick SHALL set level to SUSTAIN_LEVEL and move to SUSTAIN.
REQ-024 SUSTAIN SHALL hold level until a fall.
REQ-025 A fall in ATTACK, DECAY or SUSTAIN SHALL move to RELEASE on the next edge, with level unchanged even if tick coincides.
REQ-026 In RELEASE, on tick: level = max(level-RELEASE_STEP, 0); on reaching 0 -> IDLE.
REQ-027 A rise, or note_change with note_on=1, in DECAY, SUSTAIN or RELEASE SHALL move to ATTACK from the current level (retrigger, no reset to 0).
REQ-028 note_change in ATTACK, or with note_on=0, SHALL be ignored.
REQ-029 Priority per cycle SHALL be: fall > rise/retrigger > tick-driven update.
REQ-030 An 8-bit PWM counter SHALL free-run 0..255 and wrap.
REQ-031 pwm_out SHALL be registered as tone_in AND (pwm_cnt < env_level), giving 1-cycle latency; level 0 forces pwm_out=0 and level 255 gives 255/256 duty.
REQ-032 An idle counter SHALL increment on tick in IDLE, saturating at IDLE_TIMEOUT, and clear on leaving IDLE.
REQ-033 shutdown SHALL be 0 when the idle counter equals IDLE_TIMEOUT and 1 otherwise; it SHALL return to 1 on the cycle after a rise.

Reset
REQ-034 While resetn=0: state IDLE, env_level 0, prescaler 0, pwm_cnt 0, idle counter 0, pwm_out 0, shutdown 1, note_on history 0.
REQ-035 Reset asserted mid-note SHALL abort immediately to reset values; after release, a note_on already high SHALL count as a rise.

Verification
(Bench parameters: PRESCALE=4, ATTACK_STEP=64, DECAY_STEP=32, SUSTAIN_LEVEL=128, RELEASE_STEP=64, IDLE_TIMEOUT=3.)
REQ-036 Hold note_on=1 -> level 64,128,192,255 on successive ticks, then 223,191,159,128 and state SUSTAIN; level stays 128.
REQ-037 Drop note_on at level 128 -> RELEASE, level 64 then 0, IDLE; after 3 further ticks shutdown=0; raise note_on -> shutdown=1 next cycle.
REQ-038 Raise note_on during RELEASE at level 64 -> ATTACK, next tick level 128; pulse note_change in SUSTAIN -> ATTACK, then 192.
REQ-039 Hold tone_in=1 with level 128 -> pwm_out high for exactly 128 of each 256 cycles; tone_in=0 -> pwm_out=0.
REQ-040 Drop note_on on the same cycle as a tick in ATTACK at level 128 -> RELEASE with level 128; assert resetn=0 mid-DECAY -> level 0, IDLE, pwm_out 0 immediately.

Source files
------------

// File: rtl/tone_envelope_pwm_if.sv
// Note/tone control inputs and speaker/amplifier outputs of tone_envelope_pwm.
// Master drives the note-generator side; slave is the envelope/PWM block.
interface tone_envelope_pwm_if;
    logic       tone_in;
    logic       note_on;
    logic       note_change;
    logic       pwm_out;
    logic       shutdown;
    logic       gain;
    logic [7:0] env_level;
    logic [2:0] env_state;

    modport master (
        output tone_in, note_on, note_change,
        input  pwm_out, shutdown, gain, env_level, env_state
    );

    modport slave (
        input  tone_in, note_on, note_change,
        output pwm_out, shutdown, gain, env_level, env_state
    );
endinterface

// File: rtl/tone_envelope_pwm.sv
// ADSR envelope on a square-wave tone, rendered as PWM speaker drive with amplifier idle shutdown.
// Latency: state/level update on the edge after an event; pwm_out lags tone_in by 1 cycle.
// Backpressure: none; inputs are sampled every cycle and outputs are always valid.
module tone_envelope_pwm #(
    parameter int unsigned PRESCALE      = 25000,
    parameter int unsigned ATTACK_STEP   = 8,
    parameter int unsigned DECAY_STEP    = 2,
    parameter int unsigned SUSTAIN_LEVEL = 160,
    parameter int unsigned RELEASE_STEP  = 4,
    parameter int unsigned IDLE_TIMEOUT  = 500
) (
    input  logic                clk,
    input  logic                resetn,
    tone_envelope_pwm_if.slave  bus
);

    localparam int PW = $clog2(PRESCALE);
    localparam int IW = $clog2(IDLE_TIMEOUT + 1);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_ATTACK  = 3'd1,
        S_DECAY   = 3'd2,
        S_SUSTAIN = 3'd3,
        S_RELEASE = 3'd4
    } state_t;

    state_t          state;
    logic [7:0]      level;
    logic [PW-1:0]   pre_cnt;
    logic [IW-1:0]   idle_cnt;
    logic [7:0]      pwm_cnt;
    logic            pwm_q;
    logic            note_prev;

    logic            tick;
    logic            rise;
    logic            fall;
    logic            retrig;
    logic [8:0]      att_sum;
    logic [8:0]      decay_floor;

    assign tick        = (pre_cnt == PW'(PRESCALE - 1));
    assign rise        = bus.note_on & ~note_prev;
    assign fall        = ~bus.note_on & note_prev;
    assign retrig      = rise | (bus.note_change & bus.note_on);
    assign att_sum     = {1'b0, level} + 9'(ATTACK_STEP);
    // Any level at or below this lands exactly on the sustain floor after one decay step.
    assign decay_floor = 9'(SUSTAIN_LEVEL) + 9'(DECAY_STEP);

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            pre_cnt   <= '0;
            note_prev <= 1'b0;
        end else begin
            pre_cnt   <= tick ? '0 : pre_cnt + PW'(1);
            note_prev <= bus.note_on;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state    <= S_IDLE;
            level    <= 8'd0;
            idle_cnt <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (rise) begin
                        state    <= S_ATTACK;
                        idle_cnt <= '0;
                    end else if (tick && idle_cnt != IW'(IDLE_TIMEOUT)) begin
                        idle_cnt <= idle_cnt + IW'(1);
                    end
                end
                S_ATTACK: begin
                    if (fall) begin
                        state <= S_RELEASE;
                    end else if (tick) begin
                        if (att_sum >= 9'd255) begin
                            level <= 8'd255;
                            state <= S_DECAY;
                        end else begin
                            level <= att_sum[7:0];
                        end
                    end
                end
                S_DECAY: begin
                    if (fall) begin
                        state <= S_RELEASE;
                    end else if (retrig) begin
                        state <= S_ATTACK;
                    end else if (tick) begin
                        if ({1'b0, level} <= decay_floor) begin
                            level <= 8'(SUSTAIN_LEVEL);
                            state <= S_SUSTAIN;
                        end else begin
                            level <= level - 8'(DECAY_STEP);
                        end
                    end
                end
                S_SUSTAIN: begin
                    if (fall) begin
                        state <= S_RELEASE;
                    end else if (retrig) begin
                        state <= S_ATTACK;
                    end
                end
                S_RELEASE: begin
                    // Retrigger resumes attack from the current level, no drop to zero.
                    if (retrig) begin
                        state <= S_ATTACK;
                    end else if (tick) begin
                        if ({1'b0, level} <= 9'(RELEASE_STEP)) begin
                            level <= 8'd0;
                            state <= S_IDLE;
                        end else begin
                            level <= level - 8'(RELEASE_STEP);
                        end
                    end
                end
                default: begin
                    state <= S_IDLE;
                    level <= 8'd0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            pwm_cnt <= 8'd0;
            pwm_q   <= 1'b0;
        end else begin
            pwm_cnt <= pwm_cnt + 8'd1;
            pwm_q   <= bus.tone_in & (pwm_cnt < level);
        end
    end

    assign bus.pwm_out   = pwm_q;
    assign bus.shutdown  = (idle_cnt != IW'(IDLE_TIMEOUT));
    assign bus.gain      = 1'b0;
    assign bus.env_level = level;
    assign bus.env_state = state;

endmodule

// File: tb/tb_tone_envelope_pwm.sv
// Directed envelope/PWM/shutdown scenarios followed by random note traffic,
// all compared cycle by cycle against an arithmetic reference of the envelope rules.
module tb_tone_envelope_pwm;

    localparam int P  = 4;
    localparam int AS = 64;
    localparam int DS = 32;
    localparam int SL = 128;
    localparam int RS = 64;
    localparam int TO = 3;

    localparam int PH_IDLE = 0, PH_ATT = 1, PH_DEC = 2, PH_SUS = 3, PH_REL = 4;

    logic clk;
    logic resetn;

    tone_envelope_pwm_if bus();

    tone_envelope_pwm #(
        .PRESCALE(P), .ATTACK_STEP(AS), .DECAY_STEP(DS),
        .SUSTAIN_LEVEL(SL), .RELEASE_STEP(RS), .IDLE_TIMEOUT(TO)
    ) dut (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    int m_phase, m_level, m_div, m_idle, m_pwmcnt;
    bit m_prev, m_pwm, m_ticked;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_phase = PH_IDLE; m_level = 0; m_div = 0; m_idle = 0;
        m_pwmcnt = 0; m_prev = 0; m_pwm = 0; m_ticked = 0;
    endtask

    task automatic model_step(input bit t, input bit n, input bit c);
        bit rise, fall, tk;
        tk   = (m_div == P - 1);
        rise = n && !m_prev;
        fall = !n && m_prev;
        m_pwm    = t && (m_pwmcnt < m_level);
        m_pwmcnt = (m_pwmcnt + 1) % 256;
        if (fall && (m_phase == PH_ATT || m_phase == PH_DEC || m_phase == PH_SUS))
            m_phase = PH_REL;
        else if ((rise || (c && n)) && (m_phase == PH_DEC || m_phase == PH_SUS || m_phase == PH_REL))
            m_phase = PH_ATT;
        else if (rise && m_phase == PH_IDLE)
            m_phase = PH_ATT;
        else if (tk) begin
            case (m_phase)
                PH_ATT: begin
                    m_level = (m_level + AS > 255) ? 255 : m_level + AS;
                    if (m_level == 255) m_phase = PH_DEC;
                end
                PH_DEC: begin
                    m_level = (m_level - DS < SL) ? SL : m_level - DS;
                    if (m_level == SL) m_phase = PH_SUS;
                end
                PH_REL: begin
                    m_level = (m_level - RS < 0) ? 0 : m_level - RS;
                    if (m_level == 0) m_phase = PH_IDLE;
                end
                PH_IDLE: m_idle = (m_idle + 1 > TO) ? TO : m_idle + 1;
                default: ;
            endcase
        end
        if (m_phase != PH_IDLE) m_idle = 0;
        m_prev   = n;
        m_div    = (m_div + 1) % P;
        m_ticked = tk;
    endtask

    function automatic logic [31:0] dut_vec();
        return {18'b0, bus.env_state, bus.env_level, bus.pwm_out, bus.shutdown, bus.gain};
    endfunction

    function automatic logic [31:0] model_vec();
        return {18'b0, 3'(m_phase), 8'(m_level), m_pwm, (m_idle != TO), 1'b0};
    endfunction

    // Advance one clock; inputs are sampled as they stand before the edge.
    task automatic cycle();
        bit t, n, c;
        t = bus.tone_in; n = bus.note_on; c = bus.note_change;
        @(posedge clk);
        #1;
        if (!resetn) model_reset();
        else         model_step(t, n, c);
        check("model", dut_vec(), model_vec());
    endtask

    task automatic wait_tick();
        int g = 0;
        do begin
            cycle();
            g++;
        end while (!m_ticked && g < 2 * P);
    endtask

    task automatic wait_state(input int s);
        int g = 0;
        while (int'(bus.env_state) != s && g < 64) begin
            cycle();
            g++;
        end
        check("wait_state", bus.env_state, s);
    endtask

    task automatic async_reset_check(input string tag);
        resetn = 1'b0;
        #1;
        model_reset();
        check({tag, "_level"}, bus.env_level, 0);
        check({tag, "_state"}, bus.env_state, PH_IDLE);
        check({tag, "_pwm"}, bus.pwm_out, 0);
        check({tag, "_shutdown"}, bus.shutdown, 1);
    endtask

    initial begin
        int exp_seq[8] = '{64, 128, 192, 255, 223, 191, 159, 128};
        int hi;
        int tone_left;

        resetn = 1'b0;
        bus.tone_in = 1'b0; bus.note_on = 1'b0; bus.note_change = 1'b0;
        model_reset();
        #1;
        check("rst_state", bus.env_state, PH_IDLE);
        check("rst_level", bus.env_level, 0);
        check("rst_pwm", bus.pwm_out, 0);
        check("rst_shutdown", bus.shutdown, 1);
        check("rst_gain", bus.gain, 0);
        cycle();
        cycle();
        resetn = 1'b1;

        // Idle from reset: three ticks take the amplifier down.
        for (int i = 0; i < 14; i++) cycle();
        check("idle_shutdown", bus.shutdown, 0);

        // Full attack/decay into sustain.
        bus.note_on = 1'b1;
        cycle();
        check("rise_attack", bus.env_state, PH_ATT);
        check("rise_shutdown", bus.shutdown, 1);
        check("rise_level", bus.env_level, 0);
        for (int i = 0; i < 8; i++) begin
            wait_tick();
            check($sformatf("ad_level%0d", i), bus.env_level, exp_seq[i]);
        end
        check("sustain_state", bus.env_state, PH_SUS);
        wait_tick();
        wait_tick();
        check("sustain_hold", bus.env_level, 128);

        // Release to idle, timeout, then wake on a rise.
        bus.note_on = 1'b0;
        cycle();
        check("fall_release", bus.env_state, PH_REL);
        check("fall_level", bus.env_level, 128);
        wait_tick();
        check("rel_level64", bus.env_level, 64);
        wait_tick();
        check("rel_level0", bus.env_level, 0);
        check("rel_idle", bus.env_state, PH_IDLE);
        check("rel_shutdown_on", bus.shutdown, 1);
        wait_tick(); wait_tick(); wait_tick();
        check("timeout_shutdown", bus.shutdown, 0);
        bus.note_on = 1'b1;
        cycle();
        check("wake_shutdown", bus.shutdown, 1);

        // Retrigger from release at 64, then note_change in sustain.
        wait_tick();
        wait_tick();
        check("att128", bus.env_level, 128);
        bus.note_on = 1'b0;
        cycle();
        wait_tick();
        check("rel64", bus.env_level, 64);
        bus.note_on = 1'b1;
        cycle();
        check("retrig_state", bus.env_state, PH_ATT);
        check("retrig_level", bus.env_level, 64);
        wait_tick();
        check("retrig_next", bus.env_level, 128);
        wait_state(PH_SUS);
        bus.note_change = 1'b1;
        cycle();
        bus.note_change = 1'b0;
        check("nchg_attack", bus.env_state, PH_ATT);
        wait_tick();
        check("nchg_level", bus.env_level, 192);

        // Fall coinciding with an attack tick at level 128.
        bus.note_on = 1'b0;
        wait_state(PH_IDLE);
        bus.note_on = 1'b1;
        cycle();
        wait_tick();
        wait_tick();
        check("att128_b", bus.env_level, 128);
        while (m_div != P - 1) cycle();
        bus.note_on = 1'b0;
        cycle();
        check("fall_tick_state", bus.env_state, PH_REL);
        check("fall_tick_level", bus.env_level, 128);

        // PWM duty at level 128 in sustain.
        bus.note_on = 1'b1;
        cycle();
        wait_state(PH_SUS);
        bus.tone_in = 1'b1;
        cycle();
        hi = 0;
        for (int i = 0; i < 256; i++) begin
            cycle();
            hi += int'(bus.pwm_out);
        end
        check("pwm_duty128", hi, 128);
        bus.tone_in = 1'b0;
        cycle();
        hi = 0;
        for (int i = 0; i < 40; i++) begin
            cycle();
            hi += int'(bus.pwm_out);
        end
        check("pwm_tone_off", hi, 0);

        // Reset in the middle of decay with the tone running.
        bus.tone_in = 1'b1;
        bus.note_change = 1'b1;
        cycle();
        bus.note_change = 1'b0;
        wait_state(PH_DEC);
        async_reset_check("mid_decay");
        cycle();
        resetn = 1'b1;
        cycle();
        check("post_reset_rise", bus.env_state, PH_ATT);

        // Random note traffic.
        tone_left = 0;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 49) == 0) bus.note_on = ~bus.note_on;
            bus.note_change = ($urandom_range(0, 29) == 0);
            if (tone_left == 0) begin
                bus.tone_in = ~bus.tone_in;
                tone_left = $urandom_range(1, 8);
            end else begin
                tone_left--;
            end
            if (i % 1000 == 999) begin
                async_reset_check("rnd_reset");
                cycle();
                resetn = 1'b1;
            end
            cycle();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
